// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 16-bit pipeline.
// Runs a req/ack transaction with variable-latency main memory for loads and
// stores and stalls the pipeline while it is in flight. It also selects the
// write-back value and register, and latches the halt condition.
module mem_access #(
  parameter int TIMEOUT = 16  // max BUSY cycles before the access is aborted (2..255)
) (
  input  logic        clk,
  input  logic        reset,                 // asynchronous, active-low
  input  logic [15:0] ALUres_mem,
  input  logic [15:0] rd1_mem,
  input  logic [15:0] pcinc_mem,
  input  logic [15:0] extended_d_mem,
  input  logic [2:0]  regwrite_adr_mem,
  input  logic        main_mem_write,
  input  logic        from_main_mem_mem,
  input  logic [1:0]  regwrite_dat_controll,
  input  logic        regwrite_mem,
  input  logic        is_halt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_mem,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_adr,
  output logic        wb_regwrite,
  output logic        halted,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last BUSY count value before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_load_q;
  logic [7:0]  r_cnt;
  logic        r_halted;
  logic        r_mem_err;

  logic        w_acc;
  logic        w_cnt_last;
  logic        w_stall;

  // Once halted, no further memory transactions may start.
  assign w_acc      = (main_mem_write | from_main_mem_mem) & ~r_halted;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Stall is gated with reset so the pipeline is never frozen while in reset.
  assign w_stall = reset & (((r_state == IDLE) & w_acc) | (r_state == BUSY));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; ack takes priority over the timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_next = BUSY;
      BUSY:    if (mem_ack || w_cnt_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request registers, load capture, timeout counter and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
      r_load_q    <= 16'h0000;
      r_cnt       <= 8'd0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_mem_addr  <= ALUres_mem;
            r_mem_wdata <= rd1_mem;
            r_mem_we    <= main_mem_write;
            r_mem_req   <= 1'b1;
            r_cnt       <= 8'd0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (from_main_mem_mem) r_load_q <= mem_rdata;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (w_cnt_last) begin
            r_load_q  <= 16'h0000;
            r_mem_err <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky halt: only taken when the pipeline is not stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else if (is_halt && !w_stall) begin
      r_halted <= 1'b1;
    end
  end

  // Write-back value select.
  always_comb begin
    wb_data = ALUres_mem;
    if (from_main_mem_mem) begin
      wb_data = r_load_q;
    end else begin
      case (regwrite_dat_controll)
        2'b01:   wb_data = extended_d_mem;
        2'b10:   wb_data = pcinc_mem;
        default: wb_data = ALUres_mem;
      endcase
    end
  end

  assign wb_adr      = regwrite_adr_mem;
  assign wb_regwrite = regwrite_mem & ~w_stall & ~r_halted;
  assign stall_mem   = w_stall;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign halted      = r_halted;
  assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access (TIMEOUT=4).
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ALUres_mem, rd1_mem, pcinc_mem, extended_d_mem;
  logic [2:0]  regwrite_adr_mem;
  logic        main_mem_write, from_main_mem_mem;
  logic [1:0]  regwrite_dat_controll;
  logic        regwrite_mem, is_halt;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, stall_mem;
  logic [15:0] wb_data;
  logic [2:0]  wb_adr;
  logic        wb_regwrite, halted, mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ALUres_mem(ALUres_mem), .rd1_mem(rd1_mem), .pcinc_mem(pcinc_mem),
    .extended_d_mem(extended_d_mem), .regwrite_adr_mem(regwrite_adr_mem),
    .main_mem_write(main_mem_write), .from_main_mem_mem(from_main_mem_mem),
    .regwrite_dat_controll(regwrite_dat_controll), .regwrite_mem(regwrite_mem),
    .is_halt(is_halt), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_mem(stall_mem), .wb_data(wb_data), .wb_adr(wb_adr),
    .wb_regwrite(wb_regwrite), .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Move to just after the next rising edge; inputs are driven here.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge; outputs are sampled here.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ALUres_mem = 16'h0000; rd1_mem = 16'h0000; pcinc_mem = 16'h0000;
    extended_d_mem = 16'h0000; regwrite_adr_mem = 3'd0;
    main_mem_write = 1'b0; from_main_mem_mem = 1'b0;
    regwrite_dat_controll = 2'b00; regwrite_mem = 1'b0; is_halt = 1'b0;
    mem_rdata = 16'h0000; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    from_main_mem_mem = 1'b1;
    regwrite_mem = 1'b1;
    settle();
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_mem); end
    n_checks++; if (wb_regwrite !== 1'b1) begin n_fail++; $display("FAIL rst_wb_regwrite: got %b want 1", wb_regwrite); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    n_checks++; if (halted !== 1'b0 || mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got halted=%b err=%b want 0 0", halted, mem_err); end
    advance();
    reset = 1'b1;
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_load_k0();
    advance();
    from_main_mem_mem = 1'b1; ALUres_mem = 16'h0040; regwrite_mem = 1'b1; regwrite_adr_mem = 3'd5;
    settle();
    n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL load_c0_stall: got %b want 1", stall_mem); end
    n_checks++; if (wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL load_c0_wbreg: got %b want 0", wb_regwrite); end
    advance();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    settle();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL load_c1_req: got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL load_c1_addr: got %h want 0040", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load_c1_we: got %b want 0", mem_we); end
    n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL load_c1_stall: got %b want 1", stall_mem); end
    advance();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    settle();
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL load_done_stall: got %b want 0", stall_mem); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_done_req: got %b want 0", mem_req); end
    n_checks++; if (wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_done_wbdata: got %h want BEEF", wb_data); end
    n_checks++; if (wb_regwrite !== 1'b1) begin n_fail++; $display("FAIL load_done_wbreg: got %b want 1", wb_regwrite); end
    n_checks++; if (wb_adr !== 3'd5) begin n_fail++; $display("FAIL load_done_wbadr: got %0d want 5", wb_adr); end
    advance();
    clear_inputs();
    settle();
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL load_after_stall: got %b want 0", stall_mem); end
    $display("test_load_k0 done");
  endtask

  task automatic test_store_k3();
    advance();
    main_mem_write = 1'b1; ALUres_mem = 16'h0010; rd1_mem = 16'h1234; regwrite_mem = 1'b0;
    settle();
    n_checks++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL store_c0_stall: got %b want 1", stall_mem); end
    for (int c = 1; c <= 4; c++) begin
      advance();
      if (c == 4) mem_ack = 1'b1;
      settle();
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0010 || stall_mem !== 1'b1) begin
        n_fail++;
        $display("FAIL store_busy_c%0d: got req=%b we=%b wdata=%h addr=%h stall=%b want 1 1 1234 0010 1",
                 c, mem_req, mem_we, mem_wdata, mem_addr, stall_mem);
      end
    end
    advance();
    mem_ack = 1'b0;
    settle();
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL store_done_stall: got %b want 0", stall_mem); end
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL store_done_req: got req=%b we=%b want 0 0", mem_req, mem_we); end
    n_checks++; if (wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL store_done_wbreg: got %b want 0", wb_regwrite); end
    advance();
    clear_inputs();
    $display("test_store_k3 done");
  endtask

  task automatic test_passthrough();
    logic [1:0]  sel_v [3]  = '{2'b10, 2'b01, 2'b11};
    logic [15:0] want_v [3] = '{16'h0101, 16'hFFF3, 16'hABCD};
    for (int i = 0; i < 3; i++) begin
      regwrite_dat_controll = sel_v[i];
      pcinc_mem = 16'h0101; extended_d_mem = 16'hFFF3; ALUres_mem = 16'hABCD;
      regwrite_mem = 1'b1; regwrite_adr_mem = 3'd3;
      settle();
      n_checks++;
      if (stall_mem !== 1'b0 || wb_data !== want_v[i] || wb_regwrite !== 1'b1 || wb_adr !== 3'd3) begin
        n_fail++;
        $display("FAIL pass_sel%0d: got stall=%b wb_data=%h wbreg=%b adr=%0d want 0 %h 1 3",
                 i, stall_mem, wb_data, wb_regwrite, wb_adr, want_v[i]);
      end
      advance();
      settle();
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL pass_req%0d: got %b want 0", i, mem_req); end
      advance();
    end
    clear_inputs();
    $display("test_passthrough done");
  endtask

  task automatic test_collision();
    from_main_mem_mem = 1'b1; ALUres_mem = 16'h0022; regwrite_mem = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      advance();
      if (c == 4) begin mem_ack = 1'b1; mem_rdata = 16'hCAFE; end
    end
    advance();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    settle();
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL coll_done_stall: got %b want 0", stall_mem); end
    n_checks++; if (wb_data !== 16'hCAFE) begin n_fail++; $display("FAIL coll_wbdata: got %h want CAFE", wb_data); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL coll_err: got %b want 0", mem_err); end
    advance();
    clear_inputs();
    $display("test_collision done");
  endtask

  task automatic test_timeout();
    from_main_mem_mem = 1'b1; ALUres_mem = 16'h0080; regwrite_mem = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      advance();
      settle();
      n_checks++;
      if (mem_req !== 1'b1 || stall_mem !== 1'b1 || mem_err !== 1'b0) begin
        n_fail++;
        $display("FAIL to_busy_c%0d: got req=%b stall=%b err=%b want 1 1 0", c, mem_req, stall_mem, mem_err);
      end
    end
    advance();
    settle();
    n_checks++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL to_done_stall: got %b want 0", stall_mem); end
    n_checks++; if (wb_data !== 16'h0000) begin n_fail++; $display("FAIL to_wbdata: got %h want 0000", wb_data); end
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", mem_err); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req: got %b want 0", mem_req); end
    // Stray ack in IDLE must not touch the load register.
    advance();
    clear_inputs();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    settle();
    n_checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL to_stray_ack: got req=%b stall=%b want 0 0", mem_req, stall_mem); end
    advance();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    from_main_mem_mem = 1'b1; ALUres_mem = 16'h0090;
    settle();
    n_checks++; if (wb_data !== 16'h0000) begin n_fail++; $display("FAIL to_ack_ignored: got %h want 0000", wb_data); end
    advance();
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    advance();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    settle();
    n_checks++; if (wb_data !== 16'h7777) begin n_fail++; $display("FAIL to_next_load: got %h want 7777", wb_data); end
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
    advance();
    clear_inputs();
    $display("test_timeout done");
  endtask

  task automatic test_halt_reset();
    from_main_mem_mem = 1'b1; ALUres_mem = 16'h0200; regwrite_mem = 1'b1;
    advance();                                   // BUSY, cnt=0
    is_halt = 1'b1;
    settle();
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_busy1: got %b want 0", halted); end
    advance();                                   // BUSY, cnt=1
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    settle();
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_busy2: got %b want 0", halted); end
    advance();                                   // DONE
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    settle();
    n_checks++; if (halted !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL halt_done: got halted=%b stall=%b want 0 0", halted, stall_mem); end
    advance();                                   // IDLE, halted now set
    is_halt = 1'b0;
    from_main_mem_mem = 1'b1; ALUres_mem = 16'h0300;
    settle();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", halted); end
    n_checks++; if (stall_mem !== 1'b0 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL halt_noacc: got stall=%b wbreg=%b want 0 0", stall_mem, wb_regwrite); end
    advance();
    settle();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_noreq: got %b want 0", mem_req); end
    // Reset clears halted immediately.
    reset = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || mem_err !== 1'b0) begin n_fail++; $display("FAIL halt_rst_clear: got halted=%b err=%b want 0 0", halted, mem_err); end
    advance();
    reset = 1'b1;
    ALUres_mem = 16'h0400;                        // load still presented
    advance();                                   // BUSY
    settle();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre: got %b want 1", mem_req); end
    reset = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL rstbusy_async: got req=%b stall=%b want 0 0", mem_req, stall_mem); end
    advance();
    reset = 1'b1;
    clear_inputs();
    settle();
    n_checks++; if (stall_mem !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rstbusy_idle: got stall=%b req=%b want 0 0", stall_mem, mem_req); end
    $display("test_halt_reset done");
  endtask

  initial begin
    test_reset();
    test_load_k0();
    test_store_k3();
    test_passthrough();
    test_collision();
    test_timeout();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 16-bit pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's outputs. For loads and stores it runs a request/acknowledge transaction with the variable-latency main memory, holding the pipeline with `stall_mem` until the transaction completes. It also selects the write-back value and destination for the MEM/WB register and latches the processor halt condition.

## Interface
- `TIMEOUT`, default 16: maximum number of BUSY cycles allowed before the access is aborted; legal range 2..255.

- `clk` in 1: clock; every flop updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ALUres_mem` in 16: memory address for loads/stores; write-back value for ALU ops.
- `rd1_mem` in 16: store data.
- `pcinc_mem` in 16: PC+1, used for link write-back.
- `extended_d_mem` in 16: sign-extended immediate.
- `regwrite_adr_mem` in 3: destination register.
- `main_mem_write` in 1: instruction is a store.
- `from_main_mem_mem` in 1: instruction is a load.
- `regwrite_dat_controll` in 2: write-back source select; 00 ALU, 01 immediate, 10 pcinc, 11 ALU.
- `regwrite_mem` in 1: instruction writes a register.
- `is_halt` in 1: instruction is HLT.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: write enable, registered.
- `mem_addr` out 16: request address, registered.
- `mem_wdata` out 16: store data, registered.
- `mem_rdata` in 16: load data; valid only with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse.
- `stall_mem` out 1: freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB captures only when this is 0.
- `wb_data` out 16: write-back value.
- `wb_adr` out 3: write-back register.
- `wb_regwrite` out 1: write-back enable.
- `halted` out 1: sticky halt flag.
- `mem_err` out 1: sticky timeout flag.

## Operation
- `acc = (main_mem_write | from_main_mem_mem) & ~halted`.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `acc=1`: latch `mem_addr<=ALUres_mem`, `mem_wdata<=rd1_mem`, `mem_we<=main_mem_write`, `mem_req<=1`, clear `cnt`, go to BUSY.
  - Otherwise remain in IDLE.
- **BUSY**
  - `mem_ack=1`: `load_q<=mem_rdata` (loads only), `mem_req<=0`, `mem_we<=0`, go to DONE.
  - No ack and `cnt==TIMEOUT-1`: `load_q<=16'h0000`, `mem_err<=1`, `mem_req<=0`, `mem_we<=0`, go to DONE.
  - Otherwise `cnt<=cnt+1`. `cnt` is 8 bits and never wraps, because it stops at `TIMEOUT-1`.
- **DONE**: go to IDLE unconditionally.
- `stall_mem = (IDLE & acc) | BUSY`. It is combinational and 0 in DONE.
- `wb_data`:
  - `load_q` when `from_main_mem_mem`;
  - otherwise `extended_d_mem` for select 01, `pcinc_mem` for select 10, `ALUres_mem` for 00 and 11.
- `wb_adr = regwrite_adr_mem`.
- `wb_regwrite = regwrite_mem & ~stall_mem & ~halted`.
- `halted<=1` when `is_halt & ~stall_mem`. It stays set until reset, and no accesses start after it is set.
- `mem_ack` is ignored outside BUSY.
- Reset values: IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `load_q=0`, `cnt=0`, `halted=0`, `mem_err=0`.
  - Combinationally under reset: `stall_mem=0`, `wb_regwrite` = `regwrite_mem`.

## Timing
- Access sequence, counted from cycle 0 (load/store first visible in IDLE):
  - cycle 0: `stall_mem=1`;
  - cycle 1: `mem_req=1` (BUSY);
  - cycle 1+k: `mem_ack` arrives;
  - cycle 2+k: DONE, `stall_mem=0`, `wb_*` valid, MEM/WB captures.
  - Stall length is k+2 cycles; minimum access with k=0 occupies 3 cycles.
- In the DONE cycle, EX/MEM advances, so the next instruction is seen in IDLE at cycle 3+k. Back-to-back accesses therefore take k+3 cycles each, and the same instruction is never reissued.
- Non-memory instructions pass through with zero added latency and no stall.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable throughout BUSY.
- Ack and timeout in the same cycle: ack wins; `mem_err` is not set.
- Timeout: DONE occurs TIMEOUT cycles after BUSY entry.
- Reset mid-BUSY: `mem_req` drops asynchronously, FSM returns to IDLE, and the in-flight transaction is abandoned.

## Test plan
- **Load, k=0:** `from_main_mem_mem=1`, `ALUres_mem=16'h0040`, ack in the first BUSY cycle with `mem_rdata=16'hBEEF`. Required: `mem_addr=0040`, `mem_we=0`, `stall_mem` high for 2 cycles, then in DONE `wb_data=BEEF`, `wb_regwrite=1`.
- **Store, k=3:** `main_mem_write=1`, `ALUres_mem=16'h0010`, `rd1_mem=16'h1234`. Required: `mem_req` with `mem_we=1`, `mem_wdata=1234` held 4 cycles, stall high for 5 cycles, `wb_regwrite=0` in DONE (given `regwrite_mem=0`).
- **Pass-through:** ALU op with select 10, `pcinc_mem=16'h0101`. Required: `stall_mem=0`, `wb_data=0101`, no `mem_req`.
- **Timeout, TIMEOUT=4, no ack:** Required: DONE 4 cycles after BUSY entry, `wb_data=0000`, `mem_err=1` and sticky. A later ack arriving in IDLE is ignored.
- **Ack/timeout collision:** ack arrives exactly on the last allowed cycle. Required: `mem_rdata` is returned and `mem_err` stays 0.
- **Halt and reset:** HLT arriving while the previous access is BUSY sets `halted` only after DONE, and subsequent loads do not raise `mem_req`. Asserting reset low mid-BUSY clears `mem_req`, `halted` and the FSM immediately.
